// File: rtl/bram_burst_master.sv
// Burst initiator for a single-port block RAM: valid/ready command channel,
// streamed write data in, registered read data out, one RAM access per cycle.
module bram_burst_master #(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ADDR_WIDTH = 8,
  parameter int unsigned P_LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [P_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [P_LEN_WIDTH-1:0]  cmd_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [P_DATA_WIDTH-1:0] wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [P_DATA_WIDTH-1:0] rd_data,
  output logic                    rd_last,
  output logic                    done,
  output logic                    bram_cs,
  output logic                    bram_we,
  output logic                    bram_oe,
  output logic [P_ADDR_WIDTH-1:0] bram_addr,
  output logic [P_DATA_WIDTH-1:0] bram_wdata,
  input  logic [P_DATA_WIDTH-1:0] bram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [P_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [P_LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [P_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic                    done_q, done_d;
  logic                    wr_beat;
  logic                    rd_issue;
  logic                    last_beat;

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign done     = done_q;

  // Handshakes and RAM strobes; a read issues only when the output slot frees up
  always_comb begin
    cmd_ready  = !rst && (state_q == ST_IDLE) && !rd_valid_q;
    wr_ready   = !rst && (state_q == ST_WR);
    wr_beat    = wr_ready && wr_valid;
    rd_issue   = !rst && (state_q == ST_RD) && (!rd_valid_q || rd_ready);
    last_beat  = (beats_left_q == '0);
    bram_cs    = wr_beat || rd_issue;
    bram_we    = wr_beat;
    bram_oe    = rd_issue;
    bram_addr  = cur_addr_q;
    bram_wdata = wr_data;
  end

  // Next-state: burst sequencing, address/count stepping and read output slot
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    done_d       = 1'b0;

    if (rd_valid_q && rd_ready && !rd_issue) begin
      rd_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cur_addr_d   = cmd_addr;
          beats_left_d = cmd_len;
          state_d      = cmd_write ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        if (wr_beat) begin
          cur_addr_d   = cur_addr_q + P_ADDR_WIDTH'(1);
          beats_left_d = beats_left_q - P_LEN_WIDTH'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (rd_issue) begin
          rd_data_d    = bram_rdata;
          rd_valid_d   = 1'b1;
          rd_last_d    = last_beat;
          cur_addr_d   = cur_addr_q + P_ADDR_WIDTH'(1);
          beats_left_d = beats_left_q - P_LEN_WIDTH'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      done_q       <= done_d;
    end
  end

endmodule
